// File: rtl/telemetry_pkg.sv
// Shared definitions for the bike telemetry link (transmitter and receiver).
package telemetry_pkg;

  localparam logic [7:0]  PKT_HDR0 = 8'hAA;
  localparam logic [7:0]  PKT_HDR1 = 8'h55;
  localparam int unsigned PKT_LEN  = 8;

  // Position of each byte within the packet, header included
  localparam int unsigned BYTE_BATT_HI = 2;
  localparam int unsigned BYTE_BATT_LO = 3;
  localparam int unsigned BYTE_CURR_HI = 4;
  localparam int unsigned BYTE_CURR_LO = 5;
  localparam int unsigned BYTE_TORQ_HI = 6;
  localparam int unsigned BYTE_TORQ_LO = 7;
  localparam int unsigned DATA_BASE    = BYTE_BATT_HI;

  // Payload index as tracked by the receiver (0 = first byte after the header)
  localparam logic [2:0] IDX_BATT_HI = 3'(BYTE_BATT_HI - DATA_BASE);
  localparam logic [2:0] IDX_BATT_LO = 3'(BYTE_BATT_LO - DATA_BASE);
  localparam logic [2:0] IDX_CURR_HI = 3'(BYTE_CURR_HI - DATA_BASE);
  localparam logic [2:0] IDX_CURR_LO = 3'(BYTE_CURR_LO - DATA_BASE);
  localparam logic [2:0] IDX_TORQ_HI = 3'(BYTE_TORQ_HI - DATA_BASE);
  localparam logic [2:0] IDX_TORQ_LO = 3'(BYTE_TORQ_LO - DATA_BASE);

  typedef enum logic [1:0] {
    StHunt0,
    StHunt1,
    StData
  } rx_state_e;

endpackage

// File: rtl/rx_timeout_tmr.sv
// Inter-byte idle timer: counts idle cycles while enabled, pulses expired once the
// count reaches TIMEOUT_CYC-1, then restarts from zero. clr takes priority.
module rx_timeout_tmr #(
  parameter int unsigned TIMEOUT_CYC = 131072
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and expiry pulse
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        expired = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: hunts for the AA 55 header, reassembles the three
// 12-bit fields and publishes them atomically with a pkt_vld pulse.
module telemetry_rx #(
  parameter int unsigned TIMEOUT_CYC = 131072,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             clr_rdy,
  output logic [11:0]      batt_v,
  output logic [11:0]      avg_curr,
  output logic [11:0]      avg_torque,
  output logic             pkt_vld,
  output logic             pkt_err,
  output logic [ERR_W-1:0] err_cnt
);
  import telemetry_pkg::*;

  rx_state_e        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             clr_rdy_q, pkt_vld_q, pkt_vld_d, pkt_err_q, pkt_err_d;
  logic [11:0]      sh_batt_q, sh_batt_d, sh_curr_q, sh_curr_d, sh_torq_q, sh_torq_d;
  logic [11:0]      batt_q, batt_d, curr_q, curr_d, torq_q, torq_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             consume, tmr_expired;

  // rx_rdy is still high in the ack cycle, so it must be masked there
  assign consume = rx_rdy && !clr_rdy_q;

  rx_timeout_tmr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (consume),
    .en     (state_q != StHunt0),
    .expired(tmr_expired)
  );

  // Header hunt, payload assembly and error detection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_batt_d = sh_batt_q;
    sh_curr_d = sh_curr_q;
    sh_torq_d = sh_torq_q;
    batt_d    = batt_q;
    curr_d    = curr_q;
    torq_d    = torq_q;
    pkt_vld_d = 1'b0;
    pkt_err_d = 1'b0;
    if (consume) begin
      unique case (state_q)
        StHunt0: begin
          if (rx_data == PKT_HDR0) state_d = StHunt1;
        end
        StHunt1: begin
          if (rx_data == PKT_HDR1) begin
            state_d = StData;
            idx_d   = '0;
          end else if (rx_data != PKT_HDR0) begin
            state_d = StHunt0;
          end
        end
        StData: begin
          if (!idx_q[0]) begin
            if (rx_data[7:4] != 4'h0) begin
              pkt_err_d = 1'b1;
              sh_batt_d = '0;
              sh_curr_d = '0;
              sh_torq_d = '0;
              idx_d     = '0;
              state_d   = (rx_data == PKT_HDR0) ? StHunt1 : StHunt0;
            end else begin
              case (idx_q)
                IDX_BATT_HI: sh_batt_d[11:8] = rx_data[3:0];
                IDX_CURR_HI: sh_curr_d[11:8] = rx_data[3:0];
                IDX_TORQ_HI: sh_torq_d[11:8] = rx_data[3:0];
                default:     ;
              endcase
              idx_d = idx_q + 3'd1;
            end
          end else begin
            case (idx_q)
              IDX_BATT_LO: sh_batt_d[7:0] = rx_data;
              IDX_CURR_LO: sh_curr_d[7:0] = rx_data;
              IDX_TORQ_LO: sh_torq_d[7:0] = rx_data;
              default:     ;
            endcase
            idx_d = idx_q + 3'd1;
            if (idx_q == IDX_TORQ_LO) begin
              // Final byte bypasses the shadow so all fields publish together
              batt_d    = sh_batt_q;
              curr_d    = sh_curr_q;
              torq_d    = {sh_torq_q[11:8], rx_data};
              pkt_vld_d = 1'b1;
              idx_d     = '0;
              state_d   = StHunt0;
            end
          end
        end
        default: state_d = StHunt0;
      endcase
    end else if (tmr_expired) begin
      pkt_err_d = 1'b1;
      sh_batt_d = '0;
      sh_curr_d = '0;
      sh_torq_d = '0;
      idx_d     = '0;
      state_d   = StHunt0;
    end
  end

  // Saturating error counter, advances together with the pkt_err pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pkt_err_d && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHunt0;
      idx_q     <= '0;
      clr_rdy_q <= 1'b0;
      pkt_vld_q <= 1'b0;
      pkt_err_q <= 1'b0;
      sh_batt_q <= '0;
      sh_curr_q <= '0;
      sh_torq_q <= '0;
      batt_q    <= '0;
      curr_q    <= '0;
      torq_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clr_rdy_q <= consume;
      pkt_vld_q <= pkt_vld_d;
      pkt_err_q <= pkt_err_d;
      sh_batt_q <= sh_batt_d;
      sh_curr_q <= sh_curr_d;
      sh_torq_q <= sh_torq_d;
      batt_q    <= batt_d;
      curr_q    <= curr_d;
      torq_q    <= torq_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign clr_rdy    = clr_rdy_q;
  assign pkt_vld    = pkt_vld_q;
  assign pkt_err    = pkt_err_q;
  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx: packet table plus hand-written timeout,
// reset and saturation sequences.
module tb_telemetry_rx;

  localparam int unsigned T  = 64;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rdy = 1'b0;
  logic          clr_rdy, pkt_vld, pkt_err;
  logic [11:0]   batt_v, avg_curr, avg_torque;
  logic [EW-1:0] err_cnt;

  telemetry_rx #(
    .TIMEOUT_CYC(T),
    .ERR_W      (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .clr_rdy   (clr_rdy),
    .batt_v    (batt_v),
    .avg_curr  (avg_curr),
    .avg_torque(avg_torque),
    .pkt_vld   (pkt_vld),
    .pkt_err   (pkt_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse counters, written only here
  int clr_seen = 0, vld_seen = 0, err_seen = 0, vld_no_clr = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (clr_rdy) clr_seen++;
      if (pkt_vld) vld_seen++;
      if (pkt_err) err_seen++;
      if (pkt_vld && !clr_rdy) vld_no_clr++;
    end
  end

  typedef struct {
    string      name;
    logic [7:0] b [12];
    int         n;
    logic [11:0] eb, ec, et;
    int         evld, eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the consuming edge
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    while (clr_rdy && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    check("clr_rdy_low_before_consume", 32'(clr_rdy), 32'd0);
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [11:0] eb, input logic [11:0] ec,
                            input logic [11:0] et, input logic [7:0] ecnt);
    check({tag, ".batt_v"}, 32'(batt_v), 32'(eb));
    check({tag, ".avg_curr"}, 32'(avg_curr), 32'(ec));
    check({tag, ".avg_torque"}, 32'(avg_torque), 32'(et));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ecnt));
  endtask

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, v0, e0;
    vecs[0] = '{"good", '{8'hAA, 8'h55, 8'h0C, 8'h34, 8'h05, 8'h67, 8'h0A, 8'hBC, 0, 0, 0, 0},
                8, 12'hC34, 12'h567, 12'hABC, 1, 0, 8'd0};
    vecs[1] = '{"resync", '{8'h13, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07,
                8'h89, 0, 0}, 10, 12'h123, 12'h456, 12'h789, 1, 0, 8'd0};
    vecs[2] = '{"lo_hdr", '{8'hAA, 8'h55, 8'h00, 8'hAA, 8'h00, 8'h55, 8'h00, 8'hAA, 0, 0, 0, 0},
                8, 12'h0AA, 12'h055, 12'h0AA, 1, 0, 8'd0};
    vecs[3] = '{"bad_nib", '{8'hAA, 8'h55, 8'h1F, 8'h34, 8'h05, 8'h67, 8'h0A, 8'hBC, 0, 0, 0, 0},
                8, 12'h0AA, 12'h055, 12'h0AA, 0, 1, 8'd1};
    vecs[4] = '{"after_bad", '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h08, 8'h00, 0, 0, 0,
                0}, 8, 12'hFFF, 12'h001, 12'h800, 1, 0, 8'd1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.clr_rdy", 32'(clr_rdy), 32'd0);
    check("rst.pkt_vld", 32'(pkt_vld), 32'd0);
    check("rst.pkt_err", 32'(pkt_err), 32'd0);
    check_outs("rst", 12'h000, 12'h000, 12'h000, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Packet table
    for (int i = 0; i < 5; i++) begin
      c0 = clr_seen; v0 = vld_seen; e0 = err_seen;
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
      repeat (3) @(negedge clk);
      check({vecs[i].name, ".clr_pulses"}, 32'(clr_seen - c0), 32'(vecs[i].n));
      check({vecs[i].name, ".vld_pulses"}, 32'(vld_seen - v0), 32'(vecs[i].evld));
      check({vecs[i].name, ".err_pulses"}, 32'(err_seen - e0), 32'(vecs[i].eerr));
      check_outs(vecs[i].name, vecs[i].eb, vecs[i].ec, vecs[i].et, vecs[i].ecnt);
    end

    // Silence after a partial packet: one timeout, then idle in HUNT0
    v0 = vld_seen; e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    repeat (T + 10) @(negedge clk);
    check("tmo.err_pulses", 32'(err_seen - e0), 32'd1);
    repeat (2 * T) @(negedge clk);
    check("tmo.no_second_err", 32'(err_seen - e0), 32'd1);
    check("tmo.vld_pulses", 32'(vld_seen - v0), 32'd0);
    check_outs("tmo", 12'hFFF, 12'h001, 12'h800, 8'd2);

    // Byte consumed exactly when the count sits at TIMEOUT_CYC-1: byte wins
    v0 = vld_seen; e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h34); send_byte(8'h05); send_byte(8'h67); send_byte(8'h0A); send_byte(8'hBC);
    repeat (3) @(negedge clk);
    check("tmo_edge.err_pulses", 32'(err_seen - e0), 32'd0);
    check("tmo_edge.vld_pulses", 32'(vld_seen - v0), 32'd1);
    check_outs("tmo_edge", 12'h234, 12'h567, 12'hABC, 8'd2);

    // One cycle later the timeout fires first
    v0 = vld_seen; e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    repeat (T) @(negedge clk);
    send_byte(8'h34);
    repeat (3) @(negedge clk);
    check("tmo_late.err_pulses", 32'(err_seen - e0), 32'd1);
    check("tmo_late.vld_pulses", 32'(vld_seen - v0), 32'd0);
    check_outs("tmo_late", 12'h234, 12'h567, 12'hABC, 8'd3);

    // Reset in the middle of a packet
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    check("midrst.pkt_vld", 32'(pkt_vld), 32'd0);
    check("midrst.clr_rdy", 32'(clr_rdy), 32'd0);
    check_outs("midrst", 12'h000, 12'h000, 12'h000, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v0 = vld_seen; e0 = err_seen;
    for (int k = 0; k < 8; k++) send_byte(vecs[0].b[k]);
    repeat (3) @(negedge clk);
    check("postrst.vld_pulses", 32'(vld_seen - v0), 32'd1);
    check("postrst.err_pulses", 32'(err_seen - e0), 32'd0);
    check_outs("postrst", 12'hC34, 12'h567, 12'hABC, 8'd0);

    // Error counter saturation
    e0 = err_seen;
    for (int k = 0; k < 300; k++) begin
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1F);
    end
    repeat (3) @(negedge clk);
    check("sat.err_pulses", 32'(err_seen - e0), 32'd300);
    check_outs("sat", 12'hC34, 12'h567, 12'hABC, 8'd255);

    check("vld_with_clr", 32'(vld_no_clr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
